adsr_env: RTL and testbench

Linear ADSR envelope generator. Sits directly upstream of the amplifier stage and drives its 18-bit signed control input from a note gate. The level advances once per audio sample strobe, and gate edges retrigger or release it. One instance per voice.

---
 rtl/synth_pkg.sv | 22 ++
 rtl/adsr_step.sv | 45 ++++
 rtl/adsr_env.sv | 144 ++++++++++++++
 tb/tb_adsr_env.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the voice datapath: envelope state encoding,
// default widths for the envelope generator, and the audio/control word
// width shared with the amplifier stage.
package synth_pkg;

    // Default widths for the envelope generator
    localparam int ACC_W_DEF  = 24;  // envelope accumulator width
    localparam int RATE_W_DEF = 16;  // attack/decay/release step width
    localparam int SUS_W_DEF  = 8;   // sustain level width

    // Signed audio sample / amplifier control word width
    localparam int AUDIO_W = 18;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/adsr_step.sv
// Combinational saturating step unit shared by the ATTACK, DECAY and
// RELEASE segments.
//   acc       : current accumulator value
//   step      : per-sample step size (unsigned)
//   limit     : segment end value (ceiling when counting up, floor when down)
//   direction : 1 = add step toward ceiling, 0 = subtract step toward floor
//   next_acc  : accumulator after this step, clamped to limit
//   done      : segment has reached its limit (or step is zero)
// All arithmetic is one bit wider than the accumulator and every compare is
// unsigned, so the result never wraps.
import synth_pkg::*;

module adsr_step #(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [RATE_W-1:0] step,
    input  logic [ACC_W-1:0]  limit,
    input  logic              direction,
    output logic [ACC_W-1:0]  next_acc,
    output logic              done
);

    logic [ACC_W:0] step_w;
    logic [ACC_W:0] sum;
    logic [ACC_W:0] floor_lvl;

    assign step_w    = {{(ACC_W + 1 - RATE_W){1'b0}}, step};
    assign sum       = {1'b0, acc} + step_w;
    // Counting down: finishing when acc <= limit + step avoids ever forming
    // acc - step below the floor.
    assign floor_lvl = {1'b0, limit} + step_w;

    always_comb begin
        if (direction) begin
            done     = (sum >= {1'b0, limit}) || (step == '0);
            next_acc = done ? limit : sum[ACC_W-1:0];
        end else begin
            done     = ({1'b0, acc} <= floor_lvl) || (step == '0);
            next_acc = done ? limit : (acc - step_w[ACC_W-1:0]);
        end
    end

endmodule

// File: rtl/adsr_env.sv
// Linear ADSR envelope generator, one per voice, feeding the amplifier's
// signed control input.
//   clk, reset_n   : clock, asynchronous active-low reset
//   sample_en      : one-clock strobe per audio sample; the level only
//                    moves on a clock where it is high (no back-pressure,
//                    the strobe is never held off or acknowledged)
//   gate           : note gate, synchronous to clk; edges retrigger/release
//   attack_rate    : step added per sample in ATTACK
//   decay_rate     : step subtracted per sample in DECAY
//   sustain_level  : sustain target (upper SUS_W bits of the accumulator)
//   release_rate   : step subtracted per sample in RELEASE
//   env            : control word {0, acc[MSB -: 17]}, always non-negative
//   env_state      : current state (debug / voice allocation)
//   busy           : envelope not idle
import synth_pkg::*;

module adsr_env #(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int RATE_W = RATE_W_DEF,
    parameter int SUS_W  = SUS_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_en,
    input  logic               gate,
    input  logic [RATE_W-1:0]  attack_rate,
    input  logic [RATE_W-1:0]  decay_rate,
    input  logic [SUS_W-1:0]   sustain_level,
    input  logic [RATE_W-1:0]  release_rate,
    output logic [AUDIO_W-1:0] env,
    output logic [2:0]         env_state,
    output logic               busy
);

    localparam int              ENV_MAG_W = AUDIO_W - 1;
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    env_state_t        state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic              gate_q;
    logic              rise, fall;
    logic [ACC_W-1:0]  target;

    logic [RATE_W-1:0] step;
    logic [ACC_W-1:0]  limit;
    logic              direction;
    logic [ACC_W-1:0]  step_acc;
    logic              step_done;

    assign rise   = gate & ~gate_q;
    assign fall   = ~gate & gate_q;
    assign target = {sustain_level, {(ACC_W - SUS_W){1'b0}}};

    // Route the active segment's rate and end point into the shared step unit
    always_comb begin
        step      = release_rate;
        limit     = '0;
        direction = 1'b0;
        case (state)
            ENV_ATTACK: begin
                step      = attack_rate;
                limit     = ACC_MAX;
                direction = 1'b1;
            end
            ENV_DECAY: begin
                step      = decay_rate;
                limit     = target;
            end
            default: ;
        endcase
    end

    adsr_step #(
        .ACC_W  (ACC_W),
        .RATE_W (RATE_W)
    ) u_step (
        .acc       (acc),
        .step      (step),
        .limit     (limit),
        .direction (direction),
        .next_acc  (step_acc),
        .done      (step_done)
    );

    // Gate edges win over the sample strobe: on an edge clock only the state
    // changes and acc is kept, so a retrigger resumes from the current level.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        if (rise) begin
            state_nxt = ENV_ATTACK;
        end else if (fall && (state == ENV_ATTACK || state == ENV_DECAY ||
                              state == ENV_SUSTAIN)) begin
            state_nxt = ENV_RELEASE;
        end else if (sample_en) begin
            case (state)
                ENV_IDLE:    acc_nxt = '0;
                ENV_ATTACK: begin
                    acc_nxt = step_acc;
                    if (step_done) state_nxt = ENV_DECAY;
                end
                ENV_DECAY: begin
                    acc_nxt = step_acc;
                    if (step_done) state_nxt = ENV_SUSTAIN;
                end
                ENV_SUSTAIN: acc_nxt = target;
                ENV_RELEASE: begin
                    acc_nxt = step_acc;
                    if (step_done) state_nxt = ENV_IDLE;
                end
                default: begin
                    acc_nxt   = '0;
                    state_nxt = ENV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ENV_IDLE;
            acc    <= '0;
            gate_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            gate_q <= gate;
        end
    end

    // Output stage registered from acc/state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            env       <= '0;
            env_state <= ENV_IDLE;
            busy      <= 1'b0;
        end else begin
            env       <= {1'b0, acc[ACC_W-1 -: ENV_MAG_W]};
            env_state <= state;
            busy      <= (state != ENV_IDLE);
        end
    end

endmodule

// File: tb/tb_adsr_env.sv
module tb_adsr_env;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_en;
    logic        gate;
    logic [15:0] attack_rate, decay_rate, release_rate;
    logic [7:0]  sustain_level;
    logic [17:0] env;
    logic [2:0]  env_state;
    logic        busy;

    always #5 clk = ~clk;

    adsr_env dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_en     (sample_en),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .env           (env),
        .env_state     (env_state),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // Envelope level kept as a plain integer in accumulator units; outputs
    // are the previous clock's level/state, as seen on the registered ports.
    longint m_acc;
    int     m_st;
    bit     m_gq;
    int     m_env, m_ost;
    bit     m_busy;

    logic [21:0] exp_q[$];

    task automatic model_reset();
        m_acc = 0; m_st = 0; m_gq = 0; m_env = 0; m_ost = 0; m_busy = 0;
    endtask

    // Called just before a rising edge with the inputs the DUT will sample.
    task automatic model_edge();
        longint full = 64'd16777215;
        longint tgt  = longint'(sustain_level) * 65536;
        bit rise = gate && !m_gq;
        bit fall = !gate && m_gq;
        m_env  = int'(m_acc / 128);
        m_ost  = m_st;
        m_busy = (m_st != 0);
        if (rise) m_st = 1;
        else if (fall && m_st >= 1 && m_st <= 3) m_st = 4;
        else if (sample_en) begin
            case (m_st)
                0: m_acc = 0;
                1: if (attack_rate == 0 || m_acc + attack_rate >= full) begin
                       m_acc = full; m_st = 2;
                   end else m_acc = m_acc + attack_rate;
                2: if (decay_rate == 0 || m_acc <= tgt + decay_rate) begin
                       m_acc = tgt; m_st = 3;
                   end else m_acc = m_acc - decay_rate;
                3: m_acc = tgt;
                default: if (release_rate == 0 || m_acc <= release_rate) begin
                       m_acc = 0; m_st = 0;
                   end else m_acc = m_acc - release_rate;
            endcase
        end
        m_gq = gate;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic strobe();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic strobes(input int n);
        for (int k = 0; k < n; k++) strobe();
    endtask

    task automatic set_gate(input logic g);
        gate = g;
        tick();
        tick();
    endtask

    task automatic set_rates(input logic [15:0] a, input logic [15:0] d,
                             input logic [7:0] s, input logic [15:0] r);
        attack_rate = a; decay_rate = d; sustain_level = s; release_rate = r;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        sample_en = 1'b0;
        gate      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_out(input string name, input int e_env, input int e_st, input bit e_busy);
        check({name, ".env"}, 32'(env), 32'(e_env));
        check({name, ".state"}, 32'(env_state), 32'(e_st));
        check({name, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    function automatic logic [15:0] rnd_rate();
        case ($urandom_range(0, 3))
            0:       return 16'd0;
            1:       return 16'($urandom_range(1, 255));
            default: return 16'($urandom_range(256, 65535));
        endcase
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic        g;
        int          n;
        logic [15:0] a, d, r;
        logic [7:0]  s;
        int          e_env;
        int          e_st;
        bit          e_busy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [21:0] exp_w;

        set_rates(16'h8000, 16'h0000, 8'h80, 16'h8000);
        do_reset();
        check_out("reset", 0, 0, 0);

        //          gate  n   attack    decay     release   sus    env     st busy
        vecs[0]  = '{1'b0, 10, 16'h8000, 16'h0000, 16'h8000, 8'h80, 0,      0, 0};
        vecs[1]  = '{1'b1, 1,  16'h8000, 16'h0000, 16'h8000, 8'h80, 256,    1, 1};
        vecs[2]  = '{1'b1, 510,16'h8000, 16'h0000, 16'h8000, 8'h80, 130816, 1, 1};
        vecs[3]  = '{1'b1, 1,  16'h8000, 16'h0000, 16'h8000, 8'h80, 131071, 2, 1};
        vecs[4]  = '{1'b1, 127,16'h8000, 16'h0000, 16'h8000, 8'h80, 66047,  2, 1};
        vecs[5]  = '{1'b1, 1,  16'h8000, 16'h0000, 16'h8000, 8'h80, 65536,  3, 1};
        vecs[6]  = '{1'b1, 1,  16'h8000, 16'h0000, 16'h8000, 8'h40, 32768,  3, 1};
        vecs[7]  = '{1'b1, 1,  16'h8000, 16'h0000, 16'h8000, 8'h80, 65536,  3, 1};
        vecs[8]  = '{1'b0, 0,  16'h8000, 16'h0000, 16'h8000, 8'h80, 65536,  4, 1};
        vecs[9]  = '{1'b0, 255,16'h8000, 16'h0000, 16'h8000, 8'h80, 256,    4, 1};
        vecs[10] = '{1'b0, 1,  16'h8000, 16'h0000, 16'h8000, 8'h80, 0,      0, 0};
        // decay_rate 0x10000 does not fit 16 bits; 0xFFFF would change the
        // strobe count, so rows 3..5 use a decay step patched in below.
        for (int i = 3; i <= 7; i++) vecs[i].d = 16'h0000;

        // Decay at 0x10000/strobe is modelled as 0x8000 x2 strobes-per-row:
        // use decay_rate 0x8000 and double the strobe counts instead.
        vecs[4].d = 16'h8000; vecs[4].n = 254;
        vecs[5].d = 16'h8000; vecs[5].n = 2;
        vecs[4].e_env = 66047;

        for (int i = 0; i < 11; i++) begin
            set_rates(vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].r);
            if (gate !== vecs[i].g) set_gate(vecs[i].g);
            strobes(vecs[i].n);
            check_out($sformatf("vec%0d", i), vecs[i].e_env, vecs[i].e_st, vecs[i].e_busy);
        end

        // ---------- zero rates, sustain at full scale ----------
        set_rates(16'h0, 16'h0, 8'hFF, 16'h0);
        do_reset();
        set_gate(1'b1);
        check_out("zr_rise", 0, 1, 1);
        strobe();
        check_out("zr_s1", 131071, 2, 1);
        strobe();
        check_out("zr_s2", 130560, 3, 1);
        set_gate(1'b0);
        check_out("zr_fall", 130560, 4, 1);
        strobe();
        check_out("zr_rel", 0, 0, 0);

        // ---------- retrigger from release ----------
        set_rates(16'h0, 16'h0, 8'h80, 16'h1000);
        do_reset();
        set_gate(1'b1);
        strobes(2);
        check_out("rt_sus", 65536, 3, 1);
        set_gate(1'b0);
        strobes(1423);
        check_out("rt_rel", 20000, 4, 1);
        attack_rate = 16'h8000;
        gate        = 1'b1;
        sample_en   = 1'b1;        // strobe in the rise clock must not move acc
        tick();
        sample_en   = 1'b0;
        tick();
        check_out("rt_rise", 20000, 1, 1);
        strobe();
        check_out("rt_up", 20256, 1, 1);

        // ---------- one-clock gate pulse ----------
        set_rates(16'h8000, 16'h0, 8'h80, 16'h8000);
        do_reset();
        gate = 1'b1;
        tick();
        gate = 1'b0;
        tick();
        check("pulse.attack", 32'(env_state), 32'd1);
        tick();
        check("pulse.release", 32'(env_state), 32'd4);
        strobe();
        check_out("pulse.idle", 0, 0, 0);

        // ---------- asynchronous reset mid-attack ----------
        do_reset();
        set_gate(1'b1);
        strobes(20);
        check_out("ar_pre", 5120, 1, 1);
        #2 reset_n = 1'b0;
        #1;
        check_out("ar_async", 0, 0, 0);

        // ---------- randomized run against the model ----------
        set_rates(rnd_rate(), rnd_rate(), 8'($urandom_range(0, 255)), rnd_rate());
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 149) == 0) gate = ~gate;
            sample_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0)
                set_rates(rnd_rate(), rnd_rate(), 8'($urandom_range(0, 255)), rnd_rate());
            model_edge();
            exp_q.push_back({18'(m_env), 3'(m_ost), m_busy});
            @(posedge clk);
            @(negedge clk);
            exp_w = exp_q.pop_front();
            check($sformatf("rand%0d", c), 32'({env, env_state, busy}), 32'(exp_w));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
